// File: rtl/ext_mem_responder.sv
// ext_mem_responder: word-addressed 32-bit external memory model with programmable read latency.
module ext_mem_responder #(
  parameter int AW = 16,
  parameter int RD_LAT = 4,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          request_extmem,
  input  logic          write_extmem,
  input  logic [31:0]   addr_extmem,
  input  logic [31:0]   w_data,
  output logic          valid_extmem,
  output logic [31:0]   data_extmem,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count,
  output logic          addr_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [31:0] snap, snap_n;
  logic [31:0] mem [0:2**AW-1];
  logic issue, in_range, bus_wr;
  assign in_range = addr_extmem[31:AW] == '0;
  // backdoor load wins over a same-cycle bus write, which is then dropped entirely
  assign bus_wr = write_extmem && !ld_en;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    snap_n = snap;
    issue = 1'b0;
    case (state)
      IDLE: if (request_extmem && !write_extmem) begin
        issue = 1'b1;
        snap_n = in_range ? mem[addr_extmem[AW-1:0]] : ERR_WORD;
        cnt_n = 8'(RD_LAT - 1);
        state_n = (RD_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        state_n = !request_extmem ? IDLE : (cnt == 8'd1) ? RESP : WAIT;
        cnt_n = cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      snap <= '0;
      valid_extmem <= 1'b0;
      data_extmem <= '0;
      rd_count <= '0;
      wr_count <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      snap <= snap_n;
      valid_extmem <= state_n == RESP;
      if (state_n == RESP) data_extmem <= snap_n;
      if (state == RESP) rd_count <= rd_count + 32'd1;
      if (bus_wr && in_range) wr_count <= wr_count + 32'd1;
      if (!in_range && (bus_wr || issue)) addr_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus_wr && in_range) mem[addr_extmem[AW-1:0]] <= w_data;
  end
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: directed checks of latency, throughput, snapshot, priority, errors, abort and reset.
module tb_ext_mem_responder;
  logic clk = 0, rst = 1;
  logic request_extmem = 0, write_extmem = 0, ld_en = 0;
  logic [31:0] addr_extmem = 0, w_data = 0, ld_data = 0;
  logic [15:0] ld_addr = 0;
  logic valid_extmem, addr_err;
  logic [31:0] data_extmem, rd_count, wr_count;
  int tests = 0, fails = 0;
  logic [31:0] exp_rd = 0, exp_wr = 0;

  ext_mem_responder dut (
    .clk(clk), .rst(rst), .request_extmem(request_extmem), .write_extmem(write_extmem),
    .addr_extmem(addr_extmem), .w_data(w_data), .valid_extmem(valid_extmem),
    .data_extmem(data_extmem), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_count(rd_count), .wr_count(wr_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    write_extmem = 1; addr_extmem = a; w_data = d;
    tick();
    write_extmem = 0;
  endtask

  // issue edge is the first tick; valid expected only after the fourth (RD_LAT=4)
  task automatic do_read(input logic [31:0] a, input logic [31:0] e, input bit keep);
    request_extmem = 1; addr_extmem = a;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("valid", 32'(valid_extmem), 32'(t == 4));
      if (t == 4) begin
        check("data", data_extmem, e);
        exp_rd++;
        if (!keep) request_extmem = 0;
      end
      if (t == 5) begin
        check("rd_count", rd_count, exp_rd);
        check("data_hold", data_extmem, e);
      end
    end
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(valid_extmem), 0);
    check("rst_data", data_extmem, 0);
    check("rst_rd", rd_count, 0);
    check("rst_wr", wr_count, 0);
    check("rst_err", 32'(addr_err), 0);
    tick();
    rst = 0;
    load(16'h0010, 32'h1234_5678);
    load(16'h0030, 32'h3030_3030);
    for (int i = 0; i < 8; i++) load(16'h0100 + 16'(i), 32'hA000_0000 + 32'(i) * 32'h111);

    do_read(32'h10, 32'h1234_5678, 0);

    for (int i = 0; i < 8; i++) do_read(32'h100 + 32'(i), 32'hA000_0000 + 32'(i) * 32'h111, i != 7);
    check("b2b_rd_count", rd_count, 9);

    bus_write(32'h20, 32'hCAFE_F00D);
    exp_wr++;
    check("wr_count1", wr_count, exp_wr);
    do_read(32'h20, 32'hCAFE_F00D, 0);

    request_extmem = 1; addr_extmem = 32'h30;
    tick();
    write_extmem = 1; w_data = 32'h0000_0BAD;
    tick();
    write_extmem = 0;
    exp_wr++;
    for (int t = 3; t <= 5; t++) begin
      tick();
      check("snap_valid", 32'(valid_extmem), 32'(t == 4));
      if (t == 4) begin
        check("snap_data", data_extmem, 32'h3030_3030);
        exp_rd++;
        request_extmem = 0;
      end
    end
    check("snap_wr_count", wr_count, exp_wr);
    do_read(32'h30, 32'h0000_0BAD, 0);

    request_extmem = 1; write_extmem = 1; addr_extmem = 32'h40; w_data = 32'h4444_4444;
    tick();
    write_extmem = 0;
    exp_wr++;
    check("simul_wr_count", wr_count, exp_wr);
    check("simul_valid", 32'(valid_extmem), 0);
    do_read(32'h40, 32'h4444_4444, 0);

    check("err_pre", 32'(addr_err), 0);
    do_read(32'h0001_0000, 32'hDEAD_BEEF, 0);
    check("err_read_flag", 32'(addr_err), 1);
    bus_write(32'h0001_0020, 32'h1111_1111);
    check("err_wr_count", wr_count, exp_wr);
    do_read(32'h20, 32'hCAFE_F00D, 0);

    ld_en = 1; ld_addr = 16'h0050; ld_data = 32'h5555_5555;
    write_extmem = 1; addr_extmem = 32'h50; w_data = 32'h6666_6666;
    tick();
    ld_en = 0; write_extmem = 0;
    check("ld_prio_wr_count", wr_count, exp_wr);
    do_read(32'h50, 32'h5555_5555, 0);

    request_extmem = 1; addr_extmem = 32'h10;
    tick();
    tick();
    request_extmem = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("abort_valid", 32'(valid_extmem), 0);
    end
    check("abort_rd_count", rd_count, exp_rd);

    request_extmem = 1; addr_extmem = 32'h30;
    tick();
    tick();
    rst = 1;
    request_extmem = 0;
    #1;
    check("mid_rst_valid", 32'(valid_extmem), 0);
    check("mid_rst_data", data_extmem, 0);
    check("mid_rst_rd", rd_count, 0);
    check("mid_rst_wr", wr_count, 0);
    check("mid_rst_err", 32'(addr_err), 0);
    #2;
    rst = 0;
    exp_rd = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("post_rst_valid", 32'(valid_extmem), 0);
    end
    do_read(32'h10, 32'h1234_5678, 0);
    do_read(32'h20, 32'hCAFE_F00D, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
